// File: rtl/als_spi_reader_pkg.sv
// Shared definitions for the ambient-light-sensor SPI reader: FSM state
// encoding, default timing constants and frame field helpers.
package als_spi_reader_pkg;

  typedef enum logic [1:0] {
    ST_GAP   = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // 100 MHz clk -> 3.85 MHz SCK, 1 ms between frames.
  localparam int unsigned DEF_CLK_DIV    = 13;
  localparam int unsigned DEF_GAP_CYCLES = 100000;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned LAST_BIT   = FRAME_BITS - 1;

  // The ADC frame carries three leading zeros, the 8-bit sample, then
  // four trailing zeros and one don't-care bit.
  function automatic logic [7:0] frame_sample(input logic [15:0] frame);
    return frame[12:5];
  endfunction

  function automatic logic frame_lead_err(input logic [15:0] frame);
    return |frame[15:13];
  endfunction

endpackage

// File: rtl/als_sck_gen.sv
// Half-period timer for SCK: emits a one-clk tick every CLK_DIV clks while
// enabled, and restarts from zero whenever it is disabled.
module als_sck_gen
  import als_spi_reader_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick_o = en_i && (cnt_q == CNT_LAST);

  // Count up to the terminal value, then wrap; held at zero while idle.
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/als_spi_reader.sv
// Periodically reads one 16-bit frame from the PmodALS ADC over SPI and
// publishes the 8-bit light sample with a one-clk valid pulse.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_GAP   | cs high, sck high, wait GAP_CYCLES clks between frames
// ST_SETUP | cs low, sck high for CLK_DIV clks (chip-select setup)
// ST_SHIFT | 16 sck low/high periods, sdo sampled on each rising edge
// ST_DONE  | cs high for one clk, sample published to data
//
// cs and sck are registered from the next-state logic so they line up with
// the state register; data/data_valid/frame_err are loaded at the end of
// ST_DONE and therefore appear the clk after it.
module als_spi_reader
  import als_spi_reader_pkg::*;
#(
  parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
  parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sdo,
  output logic       cs,
  output logic       sck,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [3:0]       BIT_LAST = 4'(LAST_BIT);

  state_e           state_q, state_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [15:0]      shift_q, shift_d;
  logic             cs_q, cs_d;
  logic             sck_q, sck_d;
  logic [7:0]       data_q, data_d;
  logic             dv_q, dv_d;
  logic             ferr_q, ferr_d;

  logic             sck_en;
  logic             half_tick;

  assign sck_en = (state_q == ST_SETUP) || (state_q == ST_SHIFT);

  als_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk_i  (clk),
    .rst_i  (rst),
    .en_i   (sck_en),
    .tick_o (half_tick)
  );

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    cs_d      = cs_q;
    sck_d     = sck_q;
    data_d    = data_q;
    dv_d      = 1'b0;
    ferr_d    = ferr_q;

    unique case (state_q)
      ST_GAP: begin
        cs_d      = 1'b1;
        sck_d     = 1'b1;
        bit_cnt_d = '0;
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          state_d   = ST_SETUP;
          cs_d      = 1'b0;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end

      ST_SETUP: begin
        gap_cnt_d = '0;
        if (half_tick) begin
          state_d = ST_SHIFT;
          sck_d   = 1'b0;
        end
      end

      ST_SHIFT: begin
        if (half_tick) begin
          if (!sck_q) begin
            // Rising sck edge: the ADC changed sdo on the previous falling
            // edge, so it has been stable for a full half-period.
            sck_d   = 1'b1;
            shift_d = {shift_q[14:0], sdo};
          end else if (bit_cnt_q == BIT_LAST) begin
            state_d   = ST_DONE;
            cs_d      = 1'b1;
            bit_cnt_d = '0;
          end else begin
            sck_d     = 1'b0;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end

      ST_DONE: begin
        state_d   = ST_GAP;
        gap_cnt_d = '0;
        data_d    = frame_sample(shift_q);
        dv_d      = 1'b1;
        if (frame_lead_err(shift_q)) begin
          ferr_d = 1'b1;
        end
      end

      default: begin
        state_d   = ST_GAP;
        gap_cnt_d = '0;
        bit_cnt_d = '0;
        cs_d      = 1'b1;
        sck_d     = 1'b1;
      end
    endcase
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_GAP;
      gap_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      cs_q      <= 1'b1;
      sck_q     <= 1'b1;
      data_q    <= 8'h00;
      dv_q      <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      cs_q      <= cs_d;
      sck_q     <= sck_d;
      data_q    <= data_d;
      dv_q      <= dv_d;
      ferr_q    <= ferr_d;
    end
  end

  assign cs         = cs_q;
  assign sck        = sck_q;
  assign data       = data_q;
  assign data_valid = dv_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_als_spi_reader.sv
// Self-checking bench for als_spi_reader with a behavioural ADC model and
// a frame-level reference model (sample = bits 12..5, sticky error on any
// nonzero leading bit).
module tb_als_spi_reader;

  localparam int CLK_DIV  = 13;
  localparam int GAP      = 100;
  localparam int CS_LOW   = 33 * CLK_DIV;
  localparam int LATENCY  = 33 * CLK_DIV + 1;
  localparam int PERIOD   = GAP + 33 * CLK_DIV + 1;
  localparam int BUDGET   = 1200;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sdo = 1'b0;
  logic       cs;
  logic       sck;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;

  int compared   = 0;
  int mismatched = 0;

  als_spi_reader #(
    .CLK_DIV    (CLK_DIV),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sdo        (sdo),
    .cs         (cs),
    .sck        (sck),
    .data       (data),
    .data_valid (data_valid),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  // ADC model: latches the word to send when cs falls, then shifts it out
  // MSB first, one bit per sck falling edge.
  logic [15:0] adc_word = 16'h0000;
  logic [15:0] adc_cur  = 16'h0000;
  int          adc_idx  = 15;

  always @(negedge cs) begin
    adc_cur = adc_word;
    adc_idx = 15;
  end

  always @(negedge sck) begin
    if (!cs && adc_idx >= 0) begin
      sdo = adc_cur[adc_idx];
      adc_idx--;
    end
  end

  // Bus monitor sampled on the falling clk edge.
  int cyc          = 0;
  int cs_fall_cyc  = 0;
  int cs_low_width = 0;
  int sck_rises    = 0;
  int dv_count     = 0;
  int last_dv_cyc  = 0;
  int prev_dv_cyc  = 0;
  bit dv_long      = 1'b0;
  bit cs_prev      = 1'b1;
  bit sck_prev     = 1'b1;
  bit dv_prev      = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (cs_prev && !cs) begin
      cs_fall_cyc = cyc;
      sck_rises   = 0;
    end
    if (!cs_prev && cs) cs_low_width = cyc - cs_fall_cyc;
    if (!cs && !sck_prev && sck) sck_rises++;
    if (data_valid) begin
      dv_count++;
      if (dv_prev) dv_long = 1'b1;
      prev_dv_cyc = last_dv_cyc;
      last_dv_cyc = cyc;
    end
    cs_prev  = cs;
    sck_prev = sck;
    dv_prev  = data_valid;
  end

  // Reference model state.
  bit exp_err = 1'b0;

  function automatic logic [7:0] ref_sample(input logic [15:0] w);
    return 8'((w >> 5) & 16'h00FF);
  endfunction

  function automatic bit ref_lead_err(input logic [15:0] w);
    return (w >> 13) != 16'h0000;
  endfunction

  function automatic logic [15:0] rand_clean_word();
    logic [15:0] w;
    w = 16'($urandom_range(0, 16'h1FFF));
    return w;
  endfunction

  task automatic wait_dv(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      #1;
      if (data_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    int n;
    rst      = 1'b1;
    adc_word = 16'h1660;
    exp_err  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    compared++; if (cs !== 1'b1) begin mismatched++; $display("FAIL reset_cs got %b want 1", cs); end
    compared++; if (sck !== 1'b1) begin mismatched++; $display("FAIL reset_sck got %b want 1", sck); end
    compared++; if (data !== 8'h00) begin mismatched++; $display("FAIL reset_data got %h want 00", data); end
    compared++; if (data_valid !== 1'b0) begin mismatched++; $display("FAIL reset_dv got %b want 0", data_valid); end
    compared++; if (frame_err !== 1'b0) begin mismatched++; $display("FAIL reset_ferr got %b want 0", frame_err); end
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cs === 1'b1 && n < BUDGET);
    compared++; if (n != GAP) begin mismatched++; $display("FAIL reset_gap got %0d want %0d", n, GAP); end
  endtask

  task automatic test_single_frame;
    bit ok;
    int n;
    wait_dv(ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL b3_timeout got no data_valid want pulse"); end
    compared++; if (data !== 8'hB3) begin mismatched++; $display("FAIL b3_data got %h want b3", data); end
    compared++; if (frame_err !== 1'b0) begin mismatched++; $display("FAIL b3_ferr got %b want 0", frame_err); end
    compared++; if (last_dv_cyc - cs_fall_cyc != LATENCY) begin mismatched++; $display("FAIL b3_latency got %0d want %0d", last_dv_cyc - cs_fall_cyc, LATENCY); end
    compared++; if (cs_low_width != CS_LOW) begin mismatched++; $display("FAIL b3_cs_low got %0d want %0d", cs_low_width, CS_LOW); end
    compared++; if (sck_rises != 16) begin mismatched++; $display("FAIL b3_sck_rises got %0d want 16", sck_rises); end
    @(negedge clk);
    #1;
    compared++; if (data_valid !== 1'b0) begin mismatched++; $display("FAIL b3_dv_width got %b want 0", data_valid); end
    n = dv_count;
    repeat (80) @(negedge clk);
    #1;
    compared++; if (data !== 8'hB3) begin mismatched++; $display("FAIL b3_hold got %h want b3", data); end
    compared++; if (dv_count != n) begin mismatched++; $display("FAIL b3_no_extra_dv got %0d want %0d", dv_count, n); end
  endtask

  task automatic test_zero_frame;
    bit ok;
    int n;
    adc_word = 16'h0000;
    n = dv_count;
    wait_dv(ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL zero_timeout got no data_valid want pulse"); end
    compared++; if (data !== 8'h00) begin mismatched++; $display("FAIL zero_data got %h want 00", data); end
    compared++; if (frame_err !== 1'b0) begin mismatched++; $display("FAIL zero_ferr got %b want 0", frame_err); end
    compared++; if (dv_count != n + 1) begin mismatched++; $display("FAIL zero_dv_count got %0d want %0d", dv_count, n + 1); end
  endtask

  task automatic test_random_clean;
    bit ok;
    logic [15:0] w;
    for (int k = 0; k < 5; k++) begin
      w = rand_clean_word();
      adc_word = w;
      exp_err  = exp_err | ref_lead_err(w);
      wait_dv(ok);
      compared++; if (!ok) begin mismatched++; $display("FAIL rand_clean_timeout[%0d] got no data_valid want pulse", k); end
      compared++; if (data !== ref_sample(w)) begin mismatched++; $display("FAIL rand_clean_data[%0d] word %h got %h want %h", k, w, data, ref_sample(w)); end
      compared++; if (frame_err !== exp_err) begin mismatched++; $display("FAIL rand_clean_ferr[%0d] got %b want %b", k, frame_err, exp_err); end
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int n;
    adc_word = 16'h1FE0;
    n = dv_count;
    wait_dv(ok);
    adc_word = 16'h0020;
    compared++; if (!ok) begin mismatched++; $display("FAIL b2b_first_timeout got no data_valid want pulse"); end
    compared++; if (data !== 8'hFF) begin mismatched++; $display("FAIL b2b_first_data got %h want ff", data); end
    wait_dv(ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL b2b_second_timeout got no data_valid want pulse"); end
    compared++; if (data !== 8'h01) begin mismatched++; $display("FAIL b2b_second_data got %h want 01", data); end
    compared++; if (dv_count != n + 2) begin mismatched++; $display("FAIL b2b_dv_count got %0d want %0d", dv_count, n + 2); end
    compared++; if (last_dv_cyc - prev_dv_cyc != PERIOD) begin mismatched++; $display("FAIL b2b_period got %0d want %0d", last_dv_cyc - prev_dv_cyc, PERIOD); end
    compared++; if (dv_long !== 1'b0) begin mismatched++; $display("FAIL b2b_dv_single got %b want 0", dv_long); end
  endtask

  task automatic test_midframe_reset;
    bit ok;
    int n;
    int dv0;
    logic [15:0] w;
    adc_word = rand_clean_word();
    ok = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      #1;
      if (cs === 1'b0 && sck_rises == 8) begin
        ok = 1'b1;
        break;
      end
    end
    compared++; if (!ok) begin mismatched++; $display("FAIL midrst_reach_bit got %0d rises want 8", sck_rises); end
    #2;
    dv0 = dv_count;
    rst = 1'b1;
    exp_err = 1'b0;
    #1;
    compared++; if (cs !== 1'b1) begin mismatched++; $display("FAIL midrst_cs got %b want 1", cs); end
    compared++; if (sck !== 1'b1) begin mismatched++; $display("FAIL midrst_sck got %b want 1", sck); end
    compared++; if (data !== 8'h00) begin mismatched++; $display("FAIL midrst_data got %h want 00", data); end
    compared++; if (data_valid !== 1'b0) begin mismatched++; $display("FAIL midrst_dv got %b want 0", data_valid); end
    w = rand_clean_word();
    adc_word = w;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cs === 1'b1 && n < BUDGET);
    compared++; if (n != GAP) begin mismatched++; $display("FAIL midrst_gap got %0d want %0d", n, GAP); end
    compared++; if (dv_count != dv0) begin mismatched++; $display("FAIL midrst_no_dv got %0d want %0d", dv_count, dv0); end
    wait_dv(ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL midrst_next_timeout got no data_valid want pulse"); end
    compared++; if (data !== ref_sample(w)) begin mismatched++; $display("FAIL midrst_next_data got %h want %h", data, ref_sample(w)); end
    compared++; if (frame_err !== 1'b0) begin mismatched++; $display("FAIL midrst_ferr got %b want 0", frame_err); end
  endtask

  task automatic test_frame_err;
    bit ok;
    logic [15:0] w;
    w = {3'b010, 8'h5A, 5'b00000};
    adc_word = w;
    exp_err  = exp_err | ref_lead_err(w);
    wait_dv(ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL err_timeout got no data_valid want pulse"); end
    compared++; if (data !== 8'h5A) begin mismatched++; $display("FAIL err_data got %h want 5a", data); end
    compared++; if (frame_err !== 1'b1) begin mismatched++; $display("FAIL err_ferr got %b want 1", frame_err); end
    w = rand_clean_word();
    adc_word = w;
    wait_dv(ok);
    compared++; if (!ok) begin mismatched++; $display("FAIL err_clean_timeout got no data_valid want pulse"); end
    compared++; if (data !== ref_sample(w)) begin mismatched++; $display("FAIL err_clean_data got %h want %h", data, ref_sample(w)); end
    compared++; if (frame_err !== exp_err) begin mismatched++; $display("FAIL err_sticky got %b want %b", frame_err, exp_err); end
  endtask

  task automatic test_random_any;
    bit ok;
    logic [15:0] w;
    for (int k = 0; k < 3; k++) begin
      w = 16'($urandom);
      adc_word = w;
      exp_err  = exp_err | ref_lead_err(w);
      wait_dv(ok);
      compared++; if (!ok) begin mismatched++; $display("FAIL rand_any_timeout[%0d] got no data_valid want pulse", k); end
      compared++; if (data !== ref_sample(w)) begin mismatched++; $display("FAIL rand_any_data[%0d] word %h got %h want %h", k, w, data, ref_sample(w)); end
      compared++; if (frame_err !== exp_err) begin mismatched++; $display("FAIL rand_any_ferr[%0d] got %b want %b", k, frame_err, exp_err); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset;
    test_single_frame;
    test_zero_frame;
    test_random_clean;
    test_back_to_back;
    test_midframe_reset;
    test_frame_err;
    test_random_any;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
